act_requant_buffer: RTL and testbench
=====================================

ACT_REQUANT_BUFFER -- requirements
Module: act_requant_buffer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, width of the signed accumulator input.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of the signed requantized activations.
REQ-003 SHALL have parameter M, default 8, number of entries per frame.
REQ-004 SHALL have parameter SHIFT_W, default 5, width of the shift-amount input.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_data  input  ACC_WIDTH signed  accumulator value from the upstream linear stage.
REQ-008 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-009 SHALL have port in_done  input  1  upstream frame-complete pulse.
REQ-010 SHALL have port shift  input  SHIFT_W unsigned  right-shift amount; sampled with each accepted value.
REQ-011 SHALL have port relu_en  input  1  clamp negatives to zero when 1.
REQ-012 SHALL have port consume  input  1  downstream has taken the frame.
REQ-013 SHALL have port act_out  output  [0:M-1] x DATA_WIDTH signed  buffered activations.
REQ-014 SHALL have port act_valid  output  1  act_out holds a complete frame.
REQ-015 SHALL have port count  output  $clog2(M+1)  entries written in the current frame.
REQ-016 SHALL have port sat_flag  output  1  sticky; some entry of the current frame saturated.
REQ-017 SHALL have port err  output  1  sticky protocol error.

Function
REQ-018 SHALL implement FSM states EMPTY, FILL, FULL; act_valid = 1 only in FULL.
REQ-019 SHALL requantize each accepted value: ReLU (if relu_en and in_data < 0 -> 0), then round-half-up arithmetic shift ((x + 2^(shift-1)) >>> shift; shift = 0 -> x unchanged), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-020 SHALL compute the rounding add in ACC_WIDTH+1 bits so that no wrap occurs at the most-positive input.
REQ-021 SHALL, in EMPTY or FILL with in_valid = 1, write the requantized value to act_out[count] at the clock edge and increment count; the value is visible one cycle later.
REQ-022 SHALL move EMPTY->FILL on the first write, and move to FULL on the write that makes count = M (EMPTY->FULL directly when M = 1).
REQ-023 SHALL set sat_flag when the saturation clamp changes a written value.
REQ-024 SHALL, in FULL with consume = 1 and in_valid = 0, clear count, all act_out entries and sat_flag, and go to EMPTY next cycle.
REQ-025 SHALL, in FULL with consume = 1 and in_valid = 1, clear the frame as in REQ-024 but write the new value to entry 0 (count = 1, FILL), so back-to-back frames lose no data.
REQ-026 SHALL, in FULL with in_valid = 1 and consume = 0, drop the value and set err.
REQ-027 SHALL set err on in_done while in EMPTY or FILL with count < M (short frame); the state is unchanged.
REQ-028 SHALL ignore consume outside FULL and in_done in FULL.
REQ-029 SHALL clear err only by reset.

Reset
REQ-030 SHALL, on rst asserted, asynchronously force the state to EMPTY, count = 0, all act_out = 0, act_valid = 0, sat_flag = 0 and err = 0, including mid-frame.
REQ-031 SHALL accept no in_valid data while rst is high; the first write after rst deasserts goes to entry 0.

Structure
REQ-032 SHALL take its FSM state enum type and the default ACC_WIDTH/DATA_WIDTH constants from the shared package nn_pkg.
REQ-033 SHALL place the ReLU/round/saturate datapath in a combinational sub-module requant_sat (ports: x, shift, relu_en, y, sat).

Verification (M=8, DATA_WIDTH=8, ACC_WIDTH=32)
REQ-034 SHALL cover: shift=4, relu_en=1, inputs 100,-50,5000,-5000,8,7,0,2047 -> act_out = 6,0,127,0,1,0,0,127; sat_flag = 1; act_valid = 1 one cycle after the 8th value.
REQ-035 SHALL cover: shift=0, relu_en=0, inputs -300, 127, -128 and 5 others -> act_out[0..2] = -128,127,-128; sat_flag = 1.
REQ-036 SHALL cover: full frame, then in_valid with consume = 1 in the same cycle, value 32, shift=2 -> next cycle count = 1, act_out[0] = 8, entries 1..7 = 0, act_valid = 0.
REQ-037 SHALL cover: full frame, then extra in_valid with consume = 0 -> err = 1 and act_out unchanged; then consume -> count = 0, state EMPTY, err still 1.
REQ-038 SHALL cover: 3 values, then in_done -> err = 1 and count = 3; then rst pulse -> count = 0, act_out all 0, err = 0.
REQ-039 SHALL cover: in_data = 0x7FFFFFFF, shift=31 -> act_out = 1 with no overflow.

Source files
------------

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and default widths for the activation path.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NN_ACC_WIDTH  = 32;
    localparam int NN_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// Module      : requant_sat
// Description : ReLU, round-half-up arithmetic shift and signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_sat
    import nn_pkg::*;
#(
    parameter int ACC_WIDTH  = NN_ACC_WIDTH,
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int SHIFT_W    = 5
) (
    input  logic signed [ACC_WIDTH-1:0]  x,
    input  logic        [SHIFT_W-1:0]    shift,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);

    localparam logic signed [ACC_WIDTH:0] c_max =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_min =
        {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] w_relu;
    logic signed [ACC_WIDTH:0]   w_ext;
    logic signed [ACC_WIDTH:0]   w_rnd;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH:0]   w_shr;

    // One extra bit of headroom keeps the rounding add from wrapping at the
    // most-positive accumulator value.
    assign w_relu = (relu_en && x[ACC_WIDTH-1]) ? '0 : x;
    assign w_ext  = {w_relu[ACC_WIDTH-1], w_relu};
    assign w_rnd  = (ACC_WIDTH+1)'(1) << (shift - SHIFT_W'(1));
    assign w_sum  = w_ext + w_rnd;
    assign w_shr  = (shift == '0) ? w_ext : (w_sum >>> shift);

    always_comb begin
        y   = w_shr[DATA_WIDTH-1:0];
        sat = 1'b0;
        if (w_shr > c_max) begin
            y   = c_max[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (w_shr < c_min) begin
            y   = c_min[DATA_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule : requant_sat
`default_nettype wire

// File: rtl/act_requant_buffer.sv
`default_nettype none
// ============================================================================
// Module      : act_requant_buffer
// Description : Requantizes accumulator values into an M-entry activation frame.
// Revision    : 1.0 - initial release
// ============================================================================
module act_requant_buffer
    import nn_pkg::*;
#(
    parameter int ACC_WIDTH  = NN_ACC_WIDTH,
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int M          = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [ACC_WIDTH-1:0]  in_data,
    input  logic                         in_valid,
    input  logic                         in_done,
    input  logic        [SHIFT_W-1:0]    shift,
    input  logic                         relu_en,
    input  logic                         consume,
    output logic signed [DATA_WIDTH-1:0] act_out [0:M-1],
    output logic                         act_valid,
    output logic [$clog2(M+1)-1:0]       count,
    output logic                         sat_flag,
    output logic                         err
);

    localparam int c_cw = $clog2(M+1);

    buf_state_t                  r_state;
    logic [c_cw-1:0]             r_count;
    logic signed [DATA_WIDTH-1:0] r_act [0:M-1];
    logic                        r_valid;
    logic                        r_sat;
    logic                        r_err;

    logic signed [DATA_WIDTH-1:0] w_y;
    logic                         w_sat;
    logic                         w_last;

    requant_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_W    (SHIFT_W)
    ) u_requant (
        .x       (in_data),
        .shift   (shift),
        .relu_en (relu_en),
        .y       (w_y),
        .sat     (w_sat)
    );

    assign w_last = (r_count == c_cw'(M-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < M; i++) r_act[i] <= '0;
        end else begin
            case (r_state)
                ST_EMPTY, ST_FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < M; i++)
                            if (c_cw'(i) == r_count) r_act[i] <= w_y;
                        r_count <= r_count + c_cw'(1);
                        if (w_sat) r_sat <= 1'b1;
                        if (w_last) begin
                            r_state <= ST_FULL;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                    // A done pulse coinciding with the completing write is not short.
                    if (in_done && !(in_valid && w_last)) r_err <= 1'b1;
                end
                ST_FULL: begin
                    if (consume) begin
                        for (int i = 0; i < M; i++) r_act[i] <= '0;
                        if (in_valid) begin
                            r_act[0] <= w_y;
                            r_count  <= c_cw'(1);
                            r_sat    <= w_sat;
                            if (M == 1) begin
                                r_state <= ST_FULL;
                                r_valid <= 1'b1;
                            end else begin
                                r_state <= ST_FILL;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_count <= '0;
                            r_sat   <= 1'b0;
                            r_state <= ST_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end else if (in_valid) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign act_out   = r_act;
    assign act_valid = r_valid;
    assign count     = r_count;
    assign sat_flag  = r_sat;
    assign err       = r_err;

endmodule : act_requant_buffer
`default_nettype wire

// File: tb/tb_act_requant_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_requant_buffer
// Description : Scoreboard-driven self-checking bench for act_requant_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_requant_buffer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_done = 1'b0;
    logic [4:0]         shift = '0;
    logic               relu_en = 1'b0;
    logic               consume = 1'b0;
    logic signed [7:0]  act_out [0:7];
    logic               act_valid;
    logic [3:0]         count;
    logic               sat_flag;
    logic               err;

    int total = 0;
    int bad   = 0;
    logic signed [7:0] sb[$];

    always #5 clk = ~clk;

    act_requant_buffer #(
        .ACC_WIDTH (32),
        .DATA_WIDTH(8),
        .M         (8),
        .SHIFT_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_done   (in_done),
        .shift     (shift),
        .relu_en   (relu_en),
        .consume   (consume),
        .act_out   (act_out),
        .act_valid (act_valid),
        .count     (count),
        .sat_flag  (sat_flag),
        .err       (err)
    );

    // Reference requantizer in 64-bit integer arithmetic.
    function automatic logic signed [7:0] exp_q(input longint x, input int sh, input bit relu);
        longint v;
        v = x;
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; consume = 1'b0; in_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive(input longint v, input int sh, input bit relu,
                         input logic signed [7:0] exp_v, input bit push);
        @(negedge clk);
        in_data  = v[31:0];
        shift    = sh[4:0];
        relu_en  = relu;
        in_valid = 1'b1;
        if (push) sb.push_back(exp_v);
    endtask

    task automatic idle;
        @(negedge clk);
        in_valid = 1'b0; consume = 1'b0; in_done = 1'b0;
    endtask

    task automatic test_reset;
        logic any_nz;
        do_reset();
        any_nz = 1'b0;
        for (int i = 0; i < 8; i++) if (act_out[i] !== 8'sd0) any_nz = 1'b1;
        total++;
        if (count !== 4'd0 || act_valid !== 1'b0 || sat_flag !== 1'b0 || err !== 1'b0 || any_nz) begin
            bad++;
            $display("FAIL reset_state got cnt=%0d v=%b s=%b e=%b nz=%b want 0,0,0,0,0",
                     count, act_valid, sat_flag, err, any_nz);
        end
    endtask

    task automatic test_relu_shift4;
        longint vals [8] = '{100, -50, 5000, -5000, 8, 7, 0, 2047};
        logic signed [7:0] exps [8] = '{6, 0, 127, 0, 1, 0, 0, 127};
        logic signed [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(vals[i], 4, 1'b1, exps[i], 1'b1);
            if (i == 7) begin
                total++;
                if (act_valid !== 1'b0 || count !== 4'd7) begin
                    bad++;
                    $display("FAIL relu_pre_full got v=%b cnt=%0d want v=0 cnt=7", act_valid, count);
                end
            end
        end
        idle();
        total++;
        if (act_valid !== 1'b1 || count !== 4'd8 || sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL relu_full got v=%b cnt=%0d sat=%b want 1,8,1", act_valid, count, sat_flag);
        end
        for (int i = 0; i < 8; i++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'sdx;
            total++;
            if (act_out[i] !== e) begin
                bad++;
                $display("FAIL relu_entry[%0d] got=%0d want=%0d", i, act_out[i], e);
            end
        end
    endtask

    task automatic test_sat_noshift;
        longint vals [8] = '{-300, 127, -128, 1, 2, -1, 50, -50};
        logic signed [7:0] exps [8] = '{-128, 127, -128, 1, 2, -1, 50, -50};
        logic signed [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) drive(vals[i], 0, 1'b0, exps[i], 1'b1);
        idle();
        for (int k = 0; k < 4 && act_valid !== 1'b1; k++) @(negedge clk);
        total++;
        if (act_valid !== 1'b1 || sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_full got v=%b sat=%b want 1,1", act_valid, sat_flag);
        end
        for (int i = 0; i < 8; i++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'sdx;
            total++;
            if (act_out[i] !== e) begin
                bad++;
                $display("FAIL sat_entry[%0d] got=%0d want=%0d", i, act_out[i], e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic any_nz;
        logic signed [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) drive(longint'(13 * i - 40), 2, 1'b0, exp_q(13 * i - 40, 2, 1'b0), 1'b1);
        @(negedge clk);
        consume  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'sd32;
        shift    = 5'd2;
        relu_en  = 1'b0;
        sb.delete();
        sb.push_back(8'sd8);
        idle();
        any_nz = 1'b0;
        for (int i = 1; i < 8; i++) if (act_out[i] !== 8'sd0) any_nz = 1'b1;
        total++;
        if (count !== 4'd1 || act_out[0] !== 8'sd8 || any_nz || act_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first got cnt=%0d a0=%0d nz=%b v=%b want 1,8,0,0",
                     count, act_out[0], any_nz, act_valid);
        end
        for (int i = 1; i < 8; i++) drive(longint'(-1000 * i), 3, 1'b1, exp_q(-1000 * i, 3, 1'b1), 1'b1);
        drive(longint'(0), 0, 1'b0, 8'sd0, 1'b0);
        in_valid = 1'b0;
        total++;
        if (act_valid !== 1'b1 || count !== 4'd8) begin
            bad++;
            $display("FAIL b2b_second_full got v=%b cnt=%0d want 1,8", act_valid, count);
        end
        for (int i = 0; i < 8; i++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'sdx;
            total++;
            if (act_out[i] !== e) begin
                bad++;
                $display("FAIL b2b_entry[%0d] got=%0d want=%0d", i, act_out[i], e);
            end
        end
    endtask

    task automatic test_overflow_drop;
        logic signed [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) drive(longint'(7 * i + 3), 1, 1'b0, exp_q(7 * i + 3, 1, 1'b0), 1'b1);
        idle();
        drive(longint'(999), 1, 1'b0, 8'sd0, 1'b0);
        idle();
        total++;
        if (err !== 1'b1 || count !== 4'd8 || act_valid !== 1'b1) begin
            bad++;
            $display("FAIL drop_err got e=%b cnt=%0d v=%b want 1,8,1", err, count, act_valid);
        end
        for (int i = 0; i < 8; i++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'sdx;
            total++;
            if (act_out[i] !== e) begin
                bad++;
                $display("FAIL drop_entry[%0d] got=%0d want=%0d", i, act_out[i], e);
            end
        end
        consume = 1'b1;
        idle();
        total++;
        if (count !== 4'd0 || act_valid !== 1'b0 || err !== 1'b1 || act_out[0] !== 8'sd0) begin
            bad++;
            $display("FAIL drop_consume got cnt=%0d v=%b e=%b a0=%0d want 0,0,1,0",
                     count, act_valid, err, act_out[0]);
        end
    endtask

    task automatic test_short_frame;
        logic any_nz;
        do_reset();
        for (int i = 0; i < 3; i++) drive(longint'(20 * (i + 1)), 0, 1'b0, 8'sd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_done  = 1'b1;
        idle();
        total++;
        if (err !== 1'b1 || count !== 4'd3 || act_valid !== 1'b0) begin
            bad++;
            $display("FAIL short_err got e=%b cnt=%0d v=%b want 1,3,0", err, count, act_valid);
        end
        #2 rst = 1'b1;
        #1;
        any_nz = 1'b0;
        for (int i = 0; i < 8; i++) if (act_out[i] !== 8'sd0) any_nz = 1'b1;
        total++;
        if (count !== 4'd0 || err !== 1'b0 || any_nz) begin
            bad++;
            $display("FAIL async_reset got cnt=%0d e=%b nz=%b want 0,0,0", count, err, any_nz);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(longint'(-77), 0, 1'b0, 8'sd0, 1'b0);
        idle();
        total++;
        if (act_out[0] !== -8'sd77 || count !== 4'd1) begin
            bad++;
            $display("FAIL post_reset_write got a0=%0d cnt=%0d want -77,1", act_out[0], count);
        end
    endtask

    task automatic test_max_input;
        do_reset();
        drive(longint'(32'h7FFF_FFFF), 31, 1'b0, 8'sd1, 1'b1);
        idle();
        total++;
        if (act_out[0] !== sb[0] || sat_flag !== 1'b0 || count !== 4'd1) begin
            bad++;
            $display("FAIL max_input got a0=%0d sat=%b cnt=%0d want 1,0,1", act_out[0], sat_flag, count);
        end
        void'(sb.pop_front());
    endtask

    initial begin
        test_reset();
        test_relu_shift4();
        test_sat_noshift();
        test_back_to_back();
        test_overflow_drop();
        test_short_frame();
        test_max_input();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_act_requant_buffer
`default_nettype wire
